// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: op encoding, arctangent table generator, 1/K constant.
package cordic_pkg;

  localparam logic [1:0] OP_ROT    = 2'b00;
  localparam logic [1:0] OP_VEC    = 2'b01;
  localparam logic [1:0] OP_FOLLOW = 2'b10;

  // 1/K = 0.6072529350 with 32 fractional bits, kept signed so it multiplies signed data.
  localparam int                   INV_K_FRAC = 32;
  localparam logic signed [32:0]   INV_K      = 33'sd2608131496;

  // atan(2^-(k-1)) scaled so a full circle is 2^(width+1), rounded to nearest.
  function automatic longint atan_lsb(input int width, input int k);
    real t;
    real tp;
    real sum;
    real scale;
    longint res;
    if (k == 1) begin
      res = 64'sd1 <<< (width - 2);
    end else begin
      t   = 1.0 / (2.0 ** (k - 1));
      tp  = t;
      sum = 0.0;
      for (int n = 0; n < 30; n++) begin
        if (n % 2 == 0) begin
          sum = sum + tp / (2.0 * n + 1.0);
        end else begin
          sum = sum - tp / (2.0 * n + 1.0);
        end
        tp = tp * t * t;
      end
      scale = (2.0 ** (width + 1)) / (2.0 * 3.14159265358979323846);
      res   = longint'($rtoi(sum * scale + 0.5));
    end
    return res;
  endfunction

endpackage

// File: rtl/cordic_stream_if.sv
// Sample stream bundle: valid strobe with op/tag sideband and x/y/phase payload.
interface cordic_stream_if #(
  parameter int WIDTH = 18,
  parameter int TAGW  = 4
);
  logic                    valid;
  logic [1:0]              op;
  logic [TAGW-1:0]         tag;
  logic signed [WIDTH-1:0] x;
  logic signed [WIDTH-1:0] y;
  logic [WIDTH:0]          phase;

  modport master (output valid, op, tag, x, y, phase);
  modport slave  (input  valid, op, tag, x, y, phase);
endinterface

// File: rtl/cordic_stage.sv
// One CORDIC micro-rotation by +/-atan(2^-SHIFT), with a held direction for follow samples.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int             WIDTH = 18,
  parameter int             TAGW  = 4,
  parameter int             SHIFT = 0,
  parameter logic [WIDTH:0] ATAN  = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [1:0]              in_op,
  input  logic [TAGW-1:0]         in_tag,
  input  logic signed [WIDTH-1:0] in_x,
  input  logic signed [WIDTH-1:0] in_y,
  input  logic [WIDTH:0]          in_z,
  output logic                    out_valid,
  output logic [1:0]              out_op,
  output logic [TAGW-1:0]         out_tag,
  output logic signed [WIDTH-1:0] out_x,
  output logic signed [WIDTH-1:0] out_y,
  output logic [WIDTH:0]          out_z
);

  logic                    dir_h_r;
  logic                    dir_calc_s;
  logic                    dir_use_s;
  logic signed [WIDTH-1:0] x_sh_s;
  logic signed [WIDTH-1:0] y_sh_s;
  logic signed [WIDTH-1:0] x_next_s;
  logic signed [WIDTH-1:0] y_next_s;
  logic [WIDTH:0]          z_next_s;

  // Direction select and micro-rotation; d=1 turns clockwise and advances z by atan.
  always_comb begin
    case (in_op)
      OP_ROT:  dir_calc_s = in_z[WIDTH];
      OP_VEC:  dir_calc_s = ~in_y[WIDTH-1];
      default: dir_calc_s = 1'b0;
    endcase
    if (in_op[1]) begin
      dir_use_s = ~dir_h_r;
    end else begin
      dir_use_s = dir_calc_s;
    end
    x_sh_s = in_x >>> SHIFT;
    y_sh_s = in_y >>> SHIFT;
    if (dir_use_s) begin
      x_next_s = in_x + y_sh_s;
      y_next_s = in_y - x_sh_s;
      z_next_s = in_z + ATAN;
    end else begin
      x_next_s = in_x - y_sh_s;
      y_next_s = in_y + x_sh_s;
      z_next_s = in_z - ATAN;
    end
  end

  // Data and sideband registers, clocked every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_op    <= 2'b00;
      out_tag   <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_z     <= '0;
    end else begin
      out_valid <= in_valid;
      out_op    <= in_op;
      out_tag   <= in_tag;
      out_x     <= x_next_s;
      out_y     <= y_next_s;
      out_z     <= z_next_s;
    end
  end

  // Held direction: only valid non-follow samples update it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_h_r <= 1'b0;
    end else if (in_valid && !in_op[1]) begin
      dir_h_r <= dir_calc_s;
    end else begin
      dir_h_r <= dir_h_r;
    end
  end

endmodule

// File: rtl/cordic_stream.sv
// Streaming CORDIC: input register, 180-degree pre-stage, NSTAGE micro-rotations.
// Define CORDIC_GAIN_COMP_EN to append a registered 1/K gain-compensation stage.
module cordic_stream
  import cordic_pkg::*;
#(
  parameter int WIDTH  = 18,
  parameter int NSTAGE = 18,
  parameter int TAGW   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  cordic_stream_if.slave  s_in,
  cordic_stream_if.master m_out
);

  typedef logic [WIDTH:0] phase_t;

  logic                    in_valid_r;
  logic [1:0]              in_op_r;
  logic [TAGW-1:0]         in_tag_r;
  logic signed [WIDTH-1:0] in_x_r;
  logic signed [WIDTH-1:0] in_y_r;
  phase_t                  in_phase_r;

  logic                    dir0_calc_s;
  logic                    dir0_use_s;
  logic                    dir0_h_r;
  logic signed [WIDTH-1:0] x0_s;
  logic signed [WIDTH-1:0] y0_s;
  phase_t                  z0_s;

  logic                    pre_valid_r;
  logic [1:0]              pre_op_r;
  logic [TAGW-1:0]         pre_tag_r;
  logic signed [WIDTH-1:0] pre_x_r;
  logic signed [WIDTH-1:0] pre_y_r;
  phase_t                  pre_z_r;

  logic                    st_valid_s [0:NSTAGE];
  logic [1:0]              st_op_s    [0:NSTAGE];
  logic [TAGW-1:0]         st_tag_s   [0:NSTAGE];
  logic signed [WIDTH-1:0] st_x_s     [0:NSTAGE];
  logic signed [WIDTH-1:0] st_y_s     [0:NSTAGE];
  phase_t                  st_z_s     [0:NSTAGE];

  // Input capture register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_valid_r <= 1'b0;
      in_op_r    <= 2'b00;
      in_tag_r   <= '0;
      in_x_r     <= '0;
      in_y_r     <= '0;
      in_phase_r <= '0;
    end else begin
      in_valid_r <= s_in.valid;
      in_op_r    <= s_in.op;
      in_tag_r   <= s_in.tag;
      in_x_r     <= s_in.x;
      in_y_r     <= s_in.y;
      in_phase_r <= s_in.phase;
    end
  end

  // Pre-stage folds the operand into the right half-plane; 180 degrees is its own inverse.
  always_comb begin
    case (in_op_r)
      OP_ROT:  dir0_calc_s = in_phase_r[WIDTH] ^ in_phase_r[WIDTH-1];
      OP_VEC:  dir0_calc_s = in_x_r[WIDTH-1];
      default: dir0_calc_s = 1'b0;
    endcase
    if (in_op_r[1]) begin
      dir0_use_s = dir0_h_r;
    end else begin
      dir0_use_s = dir0_calc_s;
    end
    if (dir0_use_s) begin
      x0_s = -in_x_r;
      y0_s = -in_y_r;
      z0_s = in_phase_r ^ {1'b1, {WIDTH{1'b0}}};
    end else begin
      x0_s = in_x_r;
      y0_s = in_y_r;
      z0_s = in_phase_r;
    end
  end

  // Pre-stage pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_valid_r <= 1'b0;
      pre_op_r    <= 2'b00;
      pre_tag_r   <= '0;
      pre_x_r     <= '0;
      pre_y_r     <= '0;
      pre_z_r     <= '0;
    end else begin
      pre_valid_r <= in_valid_r;
      pre_op_r    <= in_op_r;
      pre_tag_r   <= in_tag_r;
      pre_x_r     <= x0_s;
      pre_y_r     <= y0_s;
      pre_z_r     <= z0_s;
    end
  end

  // Pre-stage held direction for follow samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir0_h_r <= 1'b0;
    end else if (in_valid_r && !in_op_r[1]) begin
      dir0_h_r <= dir0_calc_s;
    end else begin
      dir0_h_r <= dir0_h_r;
    end
  end

  assign st_valid_s[0] = pre_valid_r;
  assign st_op_s[0]    = pre_op_r;
  assign st_tag_s[0]   = pre_tag_r;
  assign st_x_s[0]     = pre_x_r;
  assign st_y_s[0]     = pre_y_r;
  assign st_z_s[0]     = pre_z_r;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    localparam phase_t ATAN_K = phase_t'(atan_lsb(WIDTH, k + 1));
    cordic_stage #(
      .WIDTH (WIDTH),
      .TAGW  (TAGW),
      .SHIFT (k),
      .ATAN  (ATAN_K)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (st_valid_s[k]),
      .in_op     (st_op_s[k]),
      .in_tag    (st_tag_s[k]),
      .in_x      (st_x_s[k]),
      .in_y      (st_y_s[k]),
      .in_z      (st_z_s[k]),
      .out_valid (st_valid_s[k+1]),
      .out_op    (st_op_s[k+1]),
      .out_tag   (st_tag_s[k+1]),
      .out_x     (st_x_s[k+1]),
      .out_y     (st_y_s[k+1]),
      .out_z     (st_z_s[k+1])
    );
  end

`ifdef CORDIC_GAIN_COMP_EN
  localparam int PW = WIDTH + INV_K_FRAC + 1;
  localparam logic signed [PW-1:0] GC_HALF =
    {{(PW - INV_K_FRAC){1'b0}}, 1'b1, {(INV_K_FRAC - 1){1'b0}}};

  logic signed [PW-1:0]    gx_prod_s;
  logic signed [PW-1:0]    gy_prod_s;
  logic                    gc_valid_r;
  logic [1:0]              gc_op_r;
  logic [TAGW-1:0]         gc_tag_r;
  logic signed [WIDTH-1:0] gc_x_r;
  logic signed [WIDTH-1:0] gc_y_r;
  phase_t                  gc_z_r;

  // Scale by 1/K with round-half-up before dropping the fraction.
  always_comb begin
    gx_prod_s = st_x_s[NSTAGE] * INV_K + GC_HALF;
    gy_prod_s = st_y_s[NSTAGE] * INV_K + GC_HALF;
  end

  // Gain-compensation register; sideband delayed to stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gc_valid_r <= 1'b0;
      gc_op_r    <= 2'b00;
      gc_tag_r   <= '0;
      gc_x_r     <= '0;
      gc_y_r     <= '0;
      gc_z_r     <= '0;
    end else begin
      gc_valid_r <= st_valid_s[NSTAGE];
      gc_op_r    <= st_op_s[NSTAGE];
      gc_tag_r   <= st_tag_s[NSTAGE];
      gc_x_r     <= gx_prod_s[INV_K_FRAC +: WIDTH];
      gc_y_r     <= gy_prod_s[INV_K_FRAC +: WIDTH];
      gc_z_r     <= st_z_s[NSTAGE];
    end
  end

  assign m_out.valid = gc_valid_r;
  assign m_out.op    = gc_op_r;
  assign m_out.tag   = gc_tag_r;
  assign m_out.x     = gc_x_r;
  assign m_out.y     = gc_y_r;
  assign m_out.phase = gc_z_r;
`else
  assign m_out.valid = st_valid_s[NSTAGE];
  assign m_out.op    = st_op_s[NSTAGE];
  assign m_out.tag   = st_tag_s[NSTAGE];
  assign m_out.x     = st_x_s[NSTAGE];
  assign m_out.y     = st_y_s[NSTAGE];
  assign m_out.phase = st_z_s[NSTAGE];
`endif

endmodule
